pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 0: PC value after reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100: trap handler address.
REQ-004 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries, power of 2, at least 2.
REQ-005 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port EN, input, 1: advance enable; 0 = stall.
REQ-008 SHALL have port REDIRECT, input, 1, with TARGET, input, XLEN: branch/jump request and its destination.
REQ-009 SHALL have port TRAP, input, 1: exception entry request.
REQ-010 SHALL have port MRET, input, 1: trap return request.
REQ-011 SHALL have ports HALT_REQ, input, 1, and RESUME, input, 1: debug halt and resume requests.
REQ-012 SHALL have ports RAS_PUSH, input, 1, and RAS_POP, input, 1: call and return hints.
REQ-013 SHALL have outputs PC (XLEN), PC_PLUS4 (XLEN), EPC (XLEN), RAS_TOP (XLEN), MISALIGN (1), RAS_EMPTY (1), RAS_FULL (1), STATE (2).

Function
REQ-014 SHALL implement states BOOT=2'b00, RUN=2'b01, HALT=2'b10, reported on STATE.
REQ-015 SHALL transition BOOT->RUN unconditionally after one cycle; PC holds RESET_VECTOR during BOOT; all requests are ignored in BOOT.
REQ-016 SHALL, in RUN, transition to HALT on HALT_REQ, PC holding; in HALT, PC holds and only RESUME (->RUN) or RESET act.
REQ-017 SHALL make PC_PLUS4 = PC + 4 combinationally, modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
REQ-018 SHALL apply RUN-state PC update priority: TRAP > MRET > REDIRECT > EN; with none asserted, PC holds.
REQ-019 SHALL, on TRAP, set PC <= TRAP_VECTOR and EPC <= PC, regardless of EN.
REQ-020 SHALL, on MRET (no TRAP), set PC <= EPC; EPC unchanged; regardless of EN.
REQ-021 SHALL, on REDIRECT with EN=1 and TARGET[1:0]==0, set PC <= TARGET; REDIRECT with EN=0 is ignored.
REQ-022 SHALL, on an accepted REDIRECT with TARGET[1:0]!=0, instead trap: PC <= TRAP_VECTOR, EPC <= PC, MISALIGN = 1 for exactly the following cycle.
REQ-023 SHALL, with EN=1 and no TRAP/MRET/REDIRECT, set PC <= PC_PLUS4.
REQ-024 SHALL give HALT_REQ priority over TRAP, MRET and REDIRECT in the same RUN cycle; the PC does not update in that cycle.
REQ-025 SHALL act on RAS_PUSH/RAS_POP only in RUN with EN=1 and no TRAP or misaligned trap in that cycle.
REQ-026 SHALL, on push, write PC_PLUS4 to the new top; when full, overwrite the oldest entry circularly with the count saturating at RAS_DEPTH.
REQ-027 SHALL, on pop, remove the top; a pop when empty is a no-op.
REQ-028 SHALL, on simultaneous push and pop, replace the top with PC_PLUS4, count unchanged; when empty, this acts as a push.
REQ-029 SHALL drive RAS_TOP as the current top entry, or all zeros when empty; RAS_EMPTY when count=0; RAS_FULL when count=RAS_DEPTH.

Reset
REQ-030 SHALL, when RESET=1 at a CLK edge, set PC=RESET_VECTOR, EPC=0, STATE=BOOT, MISALIGN=0 and RAS count=0 (RAS_EMPTY=1, RAS_TOP=0), overriding every other input including mid-trap or mid-halt.
REQ-031 SHALL NOT require RAS storage entries to be cleared by reset.

Structure
REQ-032 SHALL place state encodings, the PC increment constant (4) and default vector values in shared package pc_pkg.
REQ-033 SHALL implement the return-address stack as sub-module pc_ras, parametrised by XLEN and RAS_DEPTH.

Verification
REQ-034 SHALL verify: RESET for one cycle, then EN=1 for 4 cycles -> PC sequence 0 (BOOT), 0, 4, 8, 12.
REQ-035 SHALL verify: at PC=0x10, REDIRECT with TARGET=0x40 and EN=1 -> PC=0x40; with TARGET=0x42 -> PC=0x100, EPC=0x10, MISALIGN=1 for one cycle.
REQ-036 SHALL verify: TRAP and REDIRECT in the same cycle at PC=0x20 -> PC=0x100, EPC=0x20; then MRET -> PC=0x20.
REQ-037 SHALL verify: 5 pushes at PCs 0, 4, 8, 12, 16 with RAS_DEPTH=4 -> RAS_FULL=1, RAS_TOP=0x14; 4 pops yield 0x14, 0x10, 0x0C, 0x08; a further pop leaves RAS_EMPTY=1, RAS_TOP=0.
REQ-038 SHALL verify: HALT_REQ at PC=0x30 with EN=1 -> STATE=HALT, PC stays 0x30 while TRAP is pulsed; RESUME -> RUN, PC advances to 0x34 next cycle.
REQ-039 SHALL verify: RESET asserted while in HALT with RAS non-empty -> PC=RESET_VECTOR, STATE=BOOT, RAS_EMPTY=1.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared state encodings, PC increment and default vectors for pc_unit
package pc_pkg;
  localparam logic [1:0] ST_BOOT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam int unsigned PC_INC = 4;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
  localparam int unsigned DEF_RAS_DEPTH    = 4;
endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; when full, a push overwrites the oldest entry
module pc_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   top_q, top_d, wr_ptr;
  logic [PW:0]     cnt_q, cnt_d;
  logic            wr;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_MAX);
  assign top_o   = empty_o ? '0 : mem_q[top_q];

  always_comb begin
    cnt_d  = cnt_q;
    top_d  = top_q;
    wr     = 1'b0;
    wr_ptr = top_q;
    // Push+pop on a non-empty stack replaces the top; on an empty one it degenerates to a push.
    if (push_i && pop_i && !empty_o) begin
      wr = 1'b1;
    end else if (push_i) begin
      wr     = 1'b1;
      top_d  = top_q + PTR_ONE;
      wr_ptr = top_q + PTR_ONE;
      if (!full_o) cnt_d = cnt_q + CNT_ONE;
    end else if (pop_i && !empty_o) begin
      top_d = top_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      top_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      top_q <= top_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr] <= wdata_i;
  end
endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with boot/run/halt control, trap/return and return-address stack
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int unsigned     RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EN,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] TARGET,
  input  logic            TRAP,
  input  logic            MRET,
  input  logic            HALT_REQ,
  input  logic            RESUME,
  input  logic            RAS_PUSH,
  input  logic            RAS_POP,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS4,
  output logic [XLEN-1:0] EPC,
  output logic [XLEN-1:0] RAS_TOP,
  output logic            MISALIGN,
  output logic            RAS_EMPTY,
  output logic            RAS_FULL,
  output logic [1:0]      STATE
);
  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d;
  logic            misalign_q, misalign_d;
  logic            bad_redirect, ras_en;

  assign PC       = pc_q;
  assign PC_PLUS4 = pc_q + XLEN'(PC_INC);
  assign EPC      = epc_q;
  assign MISALIGN = misalign_q;
  assign STATE    = state_q;

  // A misaligned redirect only traps when it would actually have been taken.
  assign bad_redirect = !HALT_REQ && !TRAP && !MRET && REDIRECT && EN && (TARGET[1:0] != 2'b00);
  assign ras_en       = (state_q == ST_RUN) && EN && !TRAP && !bad_redirect;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        pc_d    = RESET_VECTOR;
      end
      ST_RUN: begin
        if (HALT_REQ) begin
          state_d = ST_HALT;
        end else if (TRAP) begin
          pc_d  = TRAP_VECTOR;
          epc_d = pc_q;
        end else if (MRET) begin
          pc_d = epc_q;
        end else if (REDIRECT && EN) begin
          if (bad_redirect) begin
            pc_d       = TRAP_VECTOR;
            epc_d      = pc_q;
            misalign_d = 1'b1;
          end else begin
            pc_d = TARGET;
          end
        end else if (EN) begin
          pc_d = PC_PLUS4;
        end
      end
      ST_HALT: begin
        if (RESUME) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (RAS_PUSH && ras_en),
    .pop_i   (RAS_POP && ras_en),
    .wdata_i (PC_PLUS4),
    .top_o   (RAS_TOP),
    .empty_o (RAS_EMPTY),
    .full_o  (RAS_FULL)
  );
endmodule
